// File: rtl/csi_dphy_pkg.sv
// Shared D-PHY definitions for the CSI transmit lane: sequencer states,
// LP line states and the HS sync byte.
package csi_dphy_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LP01,
    S_LP00,
    S_HS_ZERO,
    S_SYNC,
    S_DATA,
    S_TRAIL,
    S_EXIT
  } hs_tx_state_t;

  // Encoded as {dp, dn}
  typedef enum logic [1:0] {
    LP00 = 2'b00,
    LP01 = 2'b01,
    LP11 = 2'b11
  } lp_state_t;

  localparam logic [7:0] C_HS_SYNC = 8'hB8;

  // Trail drives the inverse of the last line bit for the whole trail period
  function automatic logic [7:0] trail_byte(input logic last_bit);
    return {8{~last_bit}};
  endfunction

endpackage

// File: rtl/csi_seq_timer.sv
// Loadable down-counter used for every HS entry/exit timing interval.
// done is high while the count sits at zero.
module csi_seq_timer #(
  parameter int P_CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [P_CNT_W-1:0] load_val,
  output logic               done
);

  logic [P_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/csi_hs_tx_seq.sv
// D-PHY data-lane HS burst sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero ->
// sync -> payload -> trail -> LP-11, with all entry/exit timing in byte clocks.
module csi_hs_tx_seq
  import csi_dphy_pkg::*;
#(
  parameter int P_T_LPX        = 2,
  parameter int P_T_HS_PREPARE = 3,
  parameter int P_T_HS_ZERO    = 5,
  parameter int P_T_HS_TRAIL   = 4,
  parameter int P_T_HS_EXIT    = 6,
  parameter int P_CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_req,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       busy,
  output logic       lp_dp,
  output logic       lp_dn,
  output logic       hs_en,
  output logic [7:0] hs_data,
  output logic       underflow
);

  localparam logic [P_CNT_W-1:0] C_LD_LPX     = P_CNT_W'(P_T_LPX - 1);
  localparam logic [P_CNT_W-1:0] C_LD_PREPARE = P_CNT_W'(P_T_HS_PREPARE - 1);
  localparam logic [P_CNT_W-1:0] C_LD_ZERO    = P_CNT_W'(P_T_HS_ZERO - 1);
  localparam logic [P_CNT_W-1:0] C_LD_TRAIL   = P_CNT_W'(P_T_HS_TRAIL - 1);
  localparam logic [P_CNT_W-1:0] C_LD_EXIT    = P_CNT_W'(P_T_HS_EXIT - 1);

  hs_tx_state_t       state;
  hs_tx_state_t       state_next;
  logic               tmr_load;
  logic [P_CNT_W-1:0] tmr_load_val;
  logic               tmr_done;
  logic               last_bit;
  logic               last_bit_next;

  lp_state_t          lp_q;
  lp_state_t          lp_d;
  logic               hs_en_d;
  logic [7:0]         hs_data_d;
  logic               busy_d;
  logic               underflow_d;

  csi_seq_timer #(
    .P_CNT_W (P_CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      last_bit <= 1'b1;
    end else begin
      state    <= state_next;
      last_bit <= last_bit_next;
    end
  end

  // Output values are decided from the current state and inputs, then
  // registered together, so an accepted byte leaves on the same output cycle
  // as the DATA state that took it.
  always_comb begin
    state_next    = state;
    tmr_load      = 1'b0;
    tmr_load_val  = '0;
    last_bit_next = last_bit;
    lp_d          = LP11;
    hs_en_d       = 1'b0;
    hs_data_d     = 8'h00;
    busy_d        = (state != S_IDLE);
    underflow_d   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (tx_req) begin
          state_next   = S_LP01;
          tmr_load     = 1'b1;
          tmr_load_val = C_LD_LPX;
        end
      end

      S_LP01: begin
        lp_d = LP01;
        if (tmr_done) begin
          state_next   = S_LP00;
          tmr_load     = 1'b1;
          tmr_load_val = C_LD_PREPARE;
        end
      end

      S_LP00: begin
        lp_d = LP00;
        if (tmr_done) begin
          state_next   = S_HS_ZERO;
          tmr_load     = 1'b1;
          tmr_load_val = C_LD_ZERO;
        end
      end

      S_HS_ZERO: begin
        lp_d    = LP00;
        hs_en_d = 1'b1;
        if (tmr_done) begin
          state_next   = S_SYNC;
          tmr_load     = 1'b1;
          tmr_load_val = '0;
        end
      end

      S_SYNC: begin
        lp_d          = LP00;
        hs_en_d       = 1'b1;
        hs_data_d     = C_HS_SYNC;
        last_bit_next = C_HS_SYNC[7];
        if (tmr_done) begin
          state_next   = S_DATA;
          tmr_load     = 1'b1;
          tmr_load_val = '0;
        end
      end

      // An empty cycle before s_last is an underflow: close the burst at once
      // with trail level taken from the last byte actually sent.
      S_DATA: begin
        lp_d    = LP00;
        hs_en_d = 1'b1;
        if (s_valid) begin
          hs_data_d     = s_data;
          last_bit_next = s_data[7];
          if (s_last) begin
            state_next   = S_TRAIL;
            tmr_load     = 1'b1;
            tmr_load_val = C_LD_TRAIL;
          end
        end else begin
          hs_data_d    = trail_byte(last_bit);
          underflow_d  = 1'b1;
          state_next   = S_TRAIL;
          tmr_load     = 1'b1;
          tmr_load_val = C_LD_TRAIL;
        end
      end

      S_TRAIL: begin
        lp_d      = LP00;
        hs_en_d   = 1'b1;
        hs_data_d = trail_byte(last_bit);
        if (tmr_done) begin
          state_next   = S_EXIT;
          tmr_load     = 1'b1;
          tmr_load_val = C_LD_EXIT;
        end
      end

      S_EXIT: begin
        if (tmr_done) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lp_q      <= LP11;
      hs_en     <= 1'b0;
      hs_data   <= 8'h00;
      busy      <= 1'b0;
      underflow <= 1'b0;
      s_ready   <= 1'b0;
    end else begin
      lp_q      <= lp_d;
      hs_en     <= hs_en_d;
      hs_data   <= hs_data_d;
      busy      <= busy_d;
      underflow <= underflow_d;
      s_ready   <= (state_next == S_DATA);
    end
  end

  assign lp_dp = lp_q[1];
  assign lp_dn = lp_q[0];

endmodule

// File: tb/tb_csi_hs_tx_seq.sv
// Directed, table-driven bench for csi_hs_tx_seq: one instance with nominal
// timing and one with every timing parameter at 1.
module tb_csi_hs_tx_seq;

  logic       clk = 1'b0;
  logic       rst;

  logic       tx_req_a, s_valid_a, s_last_a;
  logic [7:0] s_data_a;
  logic       s_ready_a, busy_a, lp_dp_a, lp_dn_a, hs_en_a, underflow_a;
  logic [7:0] hs_data_a;

  logic       tx_req_b, s_valid_b, s_last_b;
  logic [7:0] s_data_b;
  logic       s_ready_b, busy_b, lp_dp_b, lp_dn_b, hs_en_b, underflow_b;
  logic [7:0] hs_data_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       tx_req;
    logic       s_valid;
    logic       s_last;
    logic [7:0] s_data;
    logic [1:0] lp;
    logic       hs_en;
    logic [7:0] hs_data;
    logic       busy;
    logic       underflow;
    logic       s_ready;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  csi_hs_tx_seq dut_nom (
    .clk       (clk),
    .rst       (rst),
    .tx_req    (tx_req_a),
    .s_data    (s_data_a),
    .s_valid   (s_valid_a),
    .s_last    (s_last_a),
    .s_ready   (s_ready_a),
    .busy      (busy_a),
    .lp_dp     (lp_dp_a),
    .lp_dn     (lp_dn_a),
    .hs_en     (hs_en_a),
    .hs_data   (hs_data_a),
    .underflow (underflow_a)
  );

  csi_hs_tx_seq #(
    .P_T_LPX        (1),
    .P_T_HS_PREPARE (1),
    .P_T_HS_ZERO    (1),
    .P_T_HS_TRAIL   (1),
    .P_T_HS_EXIT    (1),
    .P_CNT_W        (8)
  ) dut_fast (
    .clk       (clk),
    .rst       (rst),
    .tx_req    (tx_req_b),
    .s_data    (s_data_b),
    .s_valid   (s_valid_b),
    .s_last    (s_last_b),
    .s_ready   (s_ready_b),
    .busy      (busy_b),
    .lp_dp     (lp_dp_b),
    .lp_dn     (lp_dn_b),
    .hs_en     (hs_en_b),
    .hs_data   (hs_data_b),
    .underflow (underflow_b)
  );

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s vec=%0d got=0x%02h want=0x%02h", name, idx, act, exp);
    end
  endtask

  task automatic push_vec(input logic tx, input logic sv, input logic sl, input logic [7:0] sd,
                          input logic [1:0] lp, input logic en, input logic [7:0] hd,
                          input logic bz, input logic uf, input logic sr);
    vec_t v;
    v.tx_req = tx; v.s_valid = sv; v.s_last = sl; v.s_data = sd;
    v.lp = lp; v.hs_en = en; v.hs_data = hd; v.busy = bz; v.underflow = uf; v.s_ready = sr;
    vq.push_back(v);
  endtask

  // Builds the expected per-cycle trace of one burst from the phase lengths.
  // Vector 0 is the edge that samples tx_req; vector i holds the outputs
  // seen just after edge k+i.
  task automatic add_burst(input int lpx, input int prep, input int zero, input int trl, input int ext,
                           input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input bit uf, input bit hold, input bit pulse);
    logic [7:0] bytes [4];
    logic       fill_v;
    logic       last_bit;
    logic [7:0] trail_v;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    fill_v   = !uf;
    last_bit = 1'b1;
    push_vec(1'b1, fill_v, 1'b1, 8'hEE, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < lpx; i++)  push_vec(hold, fill_v, 1'b1, 8'hEE, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < prep; i++) push_vec(hold, fill_v, 1'b1, 8'hEE, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < zero; i++) push_vec(hold, fill_v, 1'b1, 8'hEE, 2'b00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    push_vec(hold, fill_v, 1'b1, 8'hEE, 2'b00, 1'b1, 8'hB8, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      vq[vq.size()-1].s_ready = 1'b1;
      push_vec(hold || (pulse && i == 0), 1'b1, (i == n-1) && !uf, bytes[i],
               2'b00, 1'b1, bytes[i], 1'b1, 1'b0, 1'b0);
      last_bit = bytes[i][7];
    end
    trail_v = {8{~last_bit}};
    if (uf) begin
      vq[vq.size()-1].s_ready = 1'b1;
      push_vec(hold, 1'b0, 1'b1, 8'hEE, 2'b00, 1'b1, trail_v, 1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < trl; i++) push_vec(hold, fill_v, 1'b1, 8'hEE, 2'b00, 1'b1, trail_v, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < ext; i++) push_vec(hold || (pulse && i == 0), fill_v, 1'b1, 8'hEE, 2'b11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    push_vec(hold, fill_v, 1'b1, 8'hEE, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_idle();
    tx_req_a = 0; s_valid_a = 0; s_last_a = 0; s_data_a = 8'h00;
    tx_req_b = 0; s_valid_b = 0; s_last_b = 0; s_data_b = 8'h00;
  endtask

  task automatic checkOutput(input bit fast, input int idx, input vec_t v);
    string p;
    p = fast ? "fast" : "nom";
    if (!fast) begin
      chk({p, ".lp"},        idx, {6'd0, lp_dp_a, lp_dn_a}, {6'd0, v.lp});
      chk({p, ".hs_en"},     idx, {7'd0, hs_en_a},          {7'd0, v.hs_en});
      chk({p, ".hs_data"},   idx, hs_data_a,                v.hs_data);
      chk({p, ".busy"},      idx, {7'd0, busy_a},           {7'd0, v.busy});
      chk({p, ".underflow"}, idx, {7'd0, underflow_a},      {7'd0, v.underflow});
      chk({p, ".s_ready"},   idx, {7'd0, s_ready_a},        {7'd0, v.s_ready});
    end else begin
      chk({p, ".lp"},        idx, {6'd0, lp_dp_b, lp_dn_b}, {6'd0, v.lp});
      chk({p, ".hs_en"},     idx, {7'd0, hs_en_b},          {7'd0, v.hs_en});
      chk({p, ".hs_data"},   idx, hs_data_b,                v.hs_data);
      chk({p, ".busy"},      idx, {7'd0, busy_b},           {7'd0, v.busy});
      chk({p, ".underflow"}, idx, {7'd0, underflow_b},      {7'd0, v.underflow});
      chk({p, ".s_ready"},   idx, {7'd0, s_ready_b},        {7'd0, v.s_ready});
    end
  endtask

  task automatic applyStimulus(input bit fast);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive_idle();
      if (!fast) begin
        tx_req_a = vq[i].tx_req; s_valid_a = vq[i].s_valid;
        s_last_a = vq[i].s_last; s_data_a  = vq[i].s_data;
      end else begin
        tx_req_b = vq[i].tx_req; s_valid_b = vq[i].s_valid;
        s_last_b = vq[i].s_last; s_data_b  = vq[i].s_data;
      end
      @(posedge clk);
      #1;
      checkOutput(fast, i, vq[i]);
    end
    @(negedge clk);
    drive_idle();
    vq.delete();
  endtask

  task automatic do_reset();
    vec_t r;
    r.tx_req = 0; r.s_valid = 0; r.s_last = 0; r.s_data = 8'h00;
    r.lp = 2'b11; r.hs_en = 0; r.hs_data = 8'h00; r.busy = 0; r.underflow = 0; r.s_ready = 0;
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput(1'b0, -1, r);
    checkOutput(1'b1, -1, r);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    do_reset();

    // Nominal burst of three bytes with stray tx_req pulses in DATA and EXIT
    add_burst(2, 3, 5, 4, 6, 3, 8'h11, 8'h22, 8'h83, 8'h00, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0);

    // Single-byte bursts: trail level follows bit 7 of the only byte
    add_burst(2, 3, 5, 4, 6, 1, 8'h7F, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0);
    add_burst(2, 3, 5, 4, 6, 1, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0);

    // Underflow after two bytes, and underflow with no byte sent at all
    add_burst(2, 3, 5, 4, 6, 2, 8'hAA, 8'h55, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0);
    add_burst(2, 3, 5, 4, 6, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0);

    // tx_req held high: the next LP-01 follows the IDLE cycle directly
    add_burst(2, 3, 5, 4, 6, 3, 8'h11, 8'h22, 8'h83, 8'h00, 1'b0, 1'b1, 1'b0);
    push_vec(1'b1, 1'b1, 1'b1, 8'hEE, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    push_vec(1'b1, 1'b1, 1'b1, 8'hEE, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0);
    do_reset();

    // Reset in the second HS-zero cycle drops straight back to LP-11
    @(negedge clk);
    tx_req_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_req_a = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst.pre_hs_en", 7, {7'd0, hs_en_a}, 8'h01);
    chk("midrst.pre_lp",    7, {6'd0, lp_dp_a, lp_dn_a}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.lp",        8, {6'd0, lp_dp_a, lp_dn_a}, 8'h03);
    chk("midrst.hs_en",     8, {7'd0, hs_en_a}, 8'h00);
    chk("midrst.busy",      8, {7'd0, busy_a}, 8'h00);
    chk("midrst.underflow", 8, {7'd0, underflow_a}, 8'h00);
    chk("midrst.s_ready",   8, {7'd0, s_ready_a}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    add_burst(2, 3, 5, 4, 6, 1, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0);

    // Minimum timing: every timed phase lasts exactly one cycle
    add_burst(1, 1, 1, 1, 1, 4, 8'h01, 8'hC3, 8'h5A, 8'h96, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1);
    add_burst(1, 1, 1, 1, 1, 1, 8'h44, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
